// File: rtl/object_drawer.sv
// Pixel engine for background fills and 8x8 sprite draws behind the plot handshake.
// Two-stage pipeline aligned to a registered sprite ROM; one pixel issued per cycle.
module object_drawer #(
  parameter int unsigned SCREEN_W    = 160,
  parameter int unsigned SCREEN_H    = 120,
  parameter logic [2:0]  BG_COLOUR   = 3'b000,
  parameter logic [2:0]  TRANSPARENT = 3'b101
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       plotSignal,
  input  logic       backgroundSignal,
  input  logic       drawBackgroundState,
  input  logic       drawObjectState,
  input  logic [7:0] object,
  input  logic [7:0] posX,
  input  logic [6:0] posY,
  output logic [9:0] spriteAddr,
  input  logic [2:0] spriteData,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       writeEn,
  output logic       done,
  output logic       backgroundDone
);

  localparam logic [8:0] XLimit = 9'(SCREEN_W);
  localparam logic [7:0] YLimit = 8'(SCREEN_H);
  localparam logic [7:0] CxLast = 8'(SCREEN_W - 1);
  localparam logic [6:0] CyLast = 7'(SCREEN_H - 1);

  typedef enum logic [2:0] {StIdle, StBg, StObj, StFlush, StDone} stateT;

  stateT      state;
  logic [7:0] cx;
  logic [6:0] cy;
  logic [3:0] idQ;
  logic [7:0] posXQ;
  logic [6:0] posYQ;
  logic       isBg;
  logic       flushCnt;

  // Stage 1: target coordinates, aligned with spriteData
  logic       s1Valid;
  logic       s1Bg;
  logic [7:0] s1X;
  logic [6:0] s1Y;

  logic [7:0] cxNext;
  logic [6:0] cyNext;
  logic       lastPixel;
  logic [8:0] tx;
  logic [7:0] ty;
  logic       tgtValid;
  logic       objOk;

  assign objOk = (object >= 8'd1) && (object <= 8'd9);

  always_comb begin
    cxNext    = cx + 8'd1;
    cyNext    = cy;
    lastPixel = 1'b0;
    if (state == StBg) begin
      if (cx == CxLast) begin
        cxNext    = '0;
        cyNext    = cy + 7'd1;
        lastPixel = (cy == CyLast);
      end
      tx = {1'b0, cx};
      ty = {1'b0, cy};
    end else begin
      if (cx == 8'd7) begin
        cxNext    = '0;
        cyNext    = cy + 7'd1;
        lastPixel = (cy == 7'd7);
      end
      tx = {1'b0, posXQ} + {6'b0, cx[2:0]};
      ty = {1'b0, posYQ} + {5'b0, cy[2:0]};
    end
    // Off-screen targets are dropped, never wrapped
    tgtValid = (tx < XLimit) && (ty < YLimit);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state          <= StIdle;
      cx             <= '0;
      cy             <= '0;
      idQ            <= '0;
      posXQ          <= '0;
      posYQ          <= '0;
      isBg           <= 1'b0;
      flushCnt       <= 1'b0;
      s1Valid        <= 1'b0;
      s1Bg           <= 1'b0;
      s1X            <= '0;
      s1Y            <= '0;
      spriteAddr     <= '0;
      x              <= '0;
      y              <= '0;
      colour         <= '0;
      writeEn        <= 1'b0;
      done           <= 1'b0;
      backgroundDone <= 1'b0;
    end else begin
      done           <= 1'b0;
      backgroundDone <= 1'b0;
      s1Valid        <= 1'b0;
      // Stage 2
      x              <= s1X;
      y              <= s1Y;
      colour         <= s1Bg ? BG_COLOUR : spriteData;
      writeEn        <= s1Valid && (s1Bg || (spriteData != TRANSPARENT));

      case (state)
        StIdle: begin
          if (plotSignal && backgroundSignal && drawBackgroundState) begin
            state <= StBg;
            isBg  <= 1'b1;
            cx    <= '0;
            cy    <= '0;
          end else if (plotSignal && drawObjectState && !backgroundSignal) begin
            isBg  <= 1'b0;
            idQ   <= object[3:0];
            posXQ <= posX;
            posYQ <= posY;
            cx    <= '0;
            cy    <= '0;
            if (objOk) begin
              state      <= StObj;
              spriteAddr <= {object[3:0], 6'b0};
            end else begin
              state <= StDone;
              done  <= 1'b1;
            end
          end
        end
        StBg, StObj: begin
          if (!plotSignal) begin
            state   <= StIdle;
            writeEn <= 1'b0;
          end else begin
            s1Valid <= tgtValid;
            s1Bg    <= (state == StBg);
            s1X     <= tx[7:0];
            s1Y     <= ty[6:0];
            cx      <= cxNext;
            cy      <= cyNext;
            // Address runs one pixel ahead to cover the ROM latency
            if (state == StObj) spriteAddr <= {idQ, cyNext[2:0], cxNext[2:0]};
            if (lastPixel) begin
              state    <= StFlush;
              flushCnt <= 1'b0;
              cx       <= '0;
              cy       <= '0;
            end
          end
        end
        StFlush: begin
          if (!plotSignal) begin
            state   <= StIdle;
            writeEn <= 1'b0;
          end else if (flushCnt) begin
            state <= StDone;
            if (isBg) backgroundDone <= 1'b1;
            else      done           <= 1'b1;
          end else begin
            flushCnt <= 1'b1;
          end
        end
        StDone:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_object_drawer.sv
// Bench for object_drawer: scoreboard of expected pixel writes plus done-pulse timing.
module tb_object_drawer;

  logic       Clock;
  logic       Reset;
  logic       plotSignal;
  logic       backgroundSignal;
  logic       drawBackgroundState;
  logic       drawObjectState;
  logic [7:0] object;
  logic [7:0] posX;
  logic [6:0] posY;
  logic [9:0] spriteAddr;
  logic [2:0] spriteData;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       writeEn;
  logic       done;
  logic       backgroundDone;

  object_drawer dut (
    .Clock              (Clock),
    .Reset              (Reset),
    .plotSignal         (plotSignal),
    .backgroundSignal   (backgroundSignal),
    .drawBackgroundState(drawBackgroundState),
    .drawObjectState    (drawObjectState),
    .object             (object),
    .posX               (posX),
    .posY               (posY),
    .spriteAddr         (spriteAddr),
    .spriteData         (spriteData),
    .x                  (x),
    .y                  (y),
    .colour             (colour),
    .writeEn            (writeEn),
    .done               (done),
    .backgroundDone     (backgroundDone)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Sprite ROM model; any wrong sprite id reads back 3'b111
  int romMode;
  function automatic logic [2:0] romVal(input logic [9:0] a);
    if (romMode == 0) return (a[9:6] == 4'd1) ? 3'b010 : 3'b111;
    if (a[9:6] != 4'd2) return 3'b111;
    return a[0] ? 3'b101 : {1'b0, a[4:3]};
  endfunction

  always @(posedge Clock) spriteData <= romVal(spriteAddr);

  int checks = 0;
  int errors = 0;

  logic [17:0] expQ[$];
  logic [17:0] obsQ[$];
  int wrCnt, firstWr, lastWr, doneCnt, doneFirst, doneLast, bgDoneCnt, bgDoneCyc, bothCnt;

  task automatic capture(input int maxCyc, input bit dropOnDone, input int abortAt,
                         input int scrambleAt);
    obsQ.delete();
    wrCnt = 0; firstWr = -1; lastWr = -1; doneCnt = 0; doneFirst = -1; doneLast = -1;
    bgDoneCnt = 0; bgDoneCyc = -1; bothCnt = 0;
    for (int cyc = 0; cyc < maxCyc; cyc++) begin
      @(posedge Clock); #1;
      if (writeEn) begin
        obsQ.push_back({x, y, colour});
        wrCnt++;
        if (firstWr < 0) firstWr = cyc;
        lastWr = cyc;
      end
      if (done) begin
        doneCnt++;
        if (doneFirst < 0) doneFirst = cyc;
        doneLast = cyc;
        if (dropOnDone) plotSignal = 1'b0;
      end
      if (backgroundDone) begin
        bgDoneCnt++;
        if (bgDoneCyc < 0) bgDoneCyc = cyc;
        if (dropOnDone) plotSignal = 1'b0;
      end
      if (done && backgroundDone) bothCnt++;
      if (cyc == abortAt) plotSignal = 1'b0;
      if (cyc == scrambleAt) begin
        object = 8'd5; posX = 8'd0; posY = 7'd0;
      end
    end
  endtask

  task automatic issueObj(input logic [7:0] id, input logic [7:0] px, input logic [6:0] py);
    object = id; posX = px; posY = py;
    backgroundSignal = 1'b0; drawBackgroundState = 1'b0; drawObjectState = 1'b1;
    plotSignal = 1'b1;
  endtask

  task automatic idleCycles(input int n);
    plotSignal = 1'b0; drawObjectState = 1'b0; drawBackgroundState = 1'b0;
    backgroundSignal = 1'b0;
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic pushSprite(input int px, input int py, input int mode);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (px + c < 160 && py + r < 120) begin
          if (mode == 0) expQ.push_back({8'(px + c), 7'(py + r), 3'b010});
          else if (c % 2 == 0) expQ.push_back({8'(px + c), 7'(py + r), {1'b0, 2'(r)}});
        end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    plotSignal = 0; backgroundSignal = 0; drawBackgroundState = 0; drawObjectState = 0;
    object = 0; posX = 0; posY = 0; romMode = 0;
    repeat (3) @(posedge Clock);
    #1;
    checks++; if (writeEn !== 1'b0) begin errors++; $display("FAIL reset_writeEn got %b want 0", writeEn); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (backgroundDone !== 1'b0) begin errors++; $display("FAIL reset_bgDone got %b want 0", backgroundDone); end
    checks++; if (x !== 8'd0) begin errors++; $display("FAIL reset_x got %0d want 0", x); end
    checks++; if (y !== 7'd0) begin errors++; $display("FAIL reset_y got %0d want 0", y); end
    checks++; if (colour !== 3'd0) begin errors++; $display("FAIL reset_colour got %0d want 0", colour); end
    checks++; if (spriteAddr !== 10'd0) begin errors++; $display("FAIL reset_spriteAddr got %0d want 0", spriteAddr); end
    @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock); #1;
  endtask

  task automatic test_background();
    expQ.delete();
    for (int r = 0; r < 120; r++)
      for (int c = 0; c < 160; c++) expQ.push_back({8'(c), 7'(r), 3'b000});
    backgroundSignal = 1'b1; drawBackgroundState = 1'b1; drawObjectState = 1'b0;
    plotSignal = 1'b1;
    capture(19210, 1'b1, -1, -1);
    idleCycles(3);
    checks++; if (wrCnt != 19200) begin errors++; $display("FAIL bg_writes got %0d want 19200", wrCnt); end
    for (int i = 0; i < obsQ.size(); i++) begin
      if (expQ.size() == 0) break;
      checks++;
      if (obsQ[i] !== expQ[0]) begin
        errors++; $display("FAIL bg_px%0d got %h want %h", i, obsQ[i], expQ[0]);
      end
      void'(expQ.pop_front());
    end
    checks++; if (firstWr != 2) begin errors++; $display("FAIL bg_first got %0d want 2", firstWr); end
    checks++; if (lastWr != 19201) begin errors++; $display("FAIL bg_last got %0d want 19201", lastWr); end
    checks++; if (bgDoneCyc != 19202) begin errors++; $display("FAIL bg_done_cyc got %0d want 19202", bgDoneCyc); end
    checks++; if (bgDoneCnt != 1 || doneCnt != 0 || bothCnt != 0) begin
      errors++; $display("FAIL bg_pulses got bg=%0d obj=%0d both=%0d want 1 0 0", bgDoneCnt, doneCnt, bothCnt);
    end
  endtask

  task automatic test_rocket(input logic [7:0] px, input logic [6:0] py, input int scrambleAt);
    romMode = 0;
    expQ.delete();
    pushSprite(px, py, 0);
    issueObj(8'd1, px, py);
    capture(80, 1'b1, -1, scrambleAt);
    idleCycles(3);
    checks++; if (wrCnt != 64) begin errors++; $display("FAIL rocket_writes got %0d want 64", wrCnt); end
    for (int i = 0; i < obsQ.size(); i++) begin
      if (expQ.size() == 0) break;
      checks++;
      if (obsQ[i] !== expQ[0]) begin
        errors++; $display("FAIL rocket_px%0d got %h want %h", i, obsQ[i], expQ[0]);
      end
      void'(expQ.pop_front());
    end
    checks++; if (firstWr != 2) begin errors++; $display("FAIL rocket_first got %0d want 2", firstWr); end
    checks++; if (lastWr != 65) begin errors++; $display("FAIL rocket_last got %0d want 65", lastWr); end
    checks++; if (doneFirst != 66 || doneCnt != 1) begin
      errors++; $display("FAIL rocket_done got cyc=%0d n=%0d want 66 1", doneFirst, doneCnt);
    end
    checks++; if (bgDoneCnt != 0) begin errors++; $display("FAIL rocket_bgdone got %0d want 0", bgDoneCnt); end
  endtask

  task automatic test_clip();
    romMode = 1;
    expQ.delete();
    pushSprite(156, 116, 1);
    issueObj(8'd2, 8'd156, 7'd116);
    capture(80, 1'b1, -1, -1);
    idleCycles(3);
    checks++; if (wrCnt != 8) begin errors++; $display("FAIL clip_writes got %0d want 8", wrCnt); end
    for (int i = 0; i < obsQ.size(); i++) begin
      if (expQ.size() == 0) break;
      checks++;
      if (obsQ[i] !== expQ[0]) begin
        errors++; $display("FAIL clip_px%0d got %h want %h", i, obsQ[i], expQ[0]);
      end
      void'(expQ.pop_front());
    end
    checks++; if (doneFirst != 66 || doneCnt != 1) begin
      errors++; $display("FAIL clip_done got cyc=%0d n=%0d want 66 1", doneFirst, doneCnt);
    end
    romMode = 0;
  endtask

  task automatic test_invalid(input logic [7:0] id);
    issueObj(id, 8'd10, 7'd10);
    capture(10, 1'b1, -1, -1);
    idleCycles(2);
    checks++; if (wrCnt != 0) begin errors++; $display("FAIL invalid%0d_writes got %0d want 0", id, wrCnt); end
    checks++; if (doneFirst != 0 || doneCnt != 1) begin
      errors++; $display("FAIL invalid%0d_done got cyc=%0d n=%0d want 0 1", id, doneFirst, doneCnt);
    end
  endtask

  task automatic test_abort();
    romMode = 0;
    expQ.delete();
    pushSprite(10, 20, 0);
    issueObj(8'd1, 8'd10, 7'd20);
    capture(80, 1'b1, 30, -1);
    idleCycles(3);
    checks++; if (wrCnt < 29 || wrCnt > 30) begin
      errors++; $display("FAIL abort_writes got %0d want 29..30", wrCnt);
    end
    checks++; if (lastWr > 31) begin errors++; $display("FAIL abort_last got %0d want <=31", lastWr); end
    for (int i = 0; i < obsQ.size(); i++) begin
      if (expQ.size() == 0) break;
      checks++;
      if (obsQ[i] !== expQ[0]) begin
        errors++; $display("FAIL abort_px%0d got %h want %h", i, obsQ[i], expQ[0]);
      end
      void'(expQ.pop_front());
    end
    checks++; if (doneCnt != 0) begin errors++; $display("FAIL abort_done got %0d want 0", doneCnt); end
    test_rocket(8'd0, 7'd0, -1);
  endtask

  task automatic test_back_to_back();
    romMode = 0;
    expQ.delete();
    pushSprite(40, 50, 0);
    pushSprite(40, 50, 0);
    issueObj(8'd1, 8'd40, 7'd50);
    capture(136, 1'b0, -1, -1);
    idleCycles(4);
    checks++; if (wrCnt != 128) begin errors++; $display("FAIL b2b_writes got %0d want 128", wrCnt); end
    for (int i = 0; i < obsQ.size(); i++) begin
      if (expQ.size() == 0) break;
      checks++;
      if (obsQ[i] !== expQ[0]) begin
        errors++; $display("FAIL b2b_px%0d got %h want %h", i, obsQ[i], expQ[0]);
      end
      void'(expQ.pop_front());
    end
    checks++; if (doneCnt != 2 || doneFirst != 66 || doneLast != 134) begin
      errors++; $display("FAIL b2b_done got n=%0d first=%0d last=%0d want 2 66 134",
                         doneCnt, doneFirst, doneLast);
    end
  endtask

  task automatic test_async_reset();
    backgroundSignal = 1'b1; drawBackgroundState = 1'b1; drawObjectState = 1'b0;
    plotSignal = 1'b1;
    repeat (501) @(posedge Clock);
    #1;
    checks++; if (writeEn !== 1'b1) begin errors++; $display("FAIL areset_pre_writeEn got %b want 1", writeEn); end
    #2;
    Reset = 1'b0;
    #1;
    checks++; if (writeEn !== 1'b0) begin errors++; $display("FAIL areset_writeEn got %b want 0", writeEn); end
    checks++; if (x !== 8'd0) begin errors++; $display("FAIL areset_x got %0d want 0", x); end
    plotSignal = 1'b0; backgroundSignal = 1'b0; drawBackgroundState = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    capture(40, 1'b1, -1, -1);
    checks++; if (bgDoneCnt != 0 || wrCnt != 0) begin
      errors++; $display("FAIL areset_after got bgDone=%0d writes=%0d want 0 0", bgDoneCnt, wrCnt);
    end
    test_rocket(8'd100, 7'd60, -1);
  endtask

  initial begin
    test_reset();
    test_background();
    test_rocket(8'd10, 7'd20, 1);
    test_clip();
    test_invalid(8'd0);
    test_invalid(8'd10);
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
